// File: rtl/spi_fsm.sv
// spi_fsm: SPI memory transaction sequencer (header, then read or write data phase).
// Define SPI_FSM_DEBUG_EN to add dbg_state and a saturating abort_cnt.
module spi_fsm #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sclk_rise,
   input  logic cs_n,
   input  logic rw_bit,
   output logic addr_we,
   output logic sr_we,
   output logic dm_we,
   output logic miso_en,
   output logic busy
`ifdef SPI_FSM_DEBUG_EN
   ,
   output logic [3:0] dbg_state,
   output logic [7:0] abort_cnt
`endif
);
   localparam int CW = $clog2(ADDR_BITS + DATA_BITS + 2);
   localparam logic [CW-1:0] HDR_LAST = CW'(ADDR_BITS);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   // Nine states do not fit in three bits, so the encoding is four bits wide.
   typedef enum logic [3:0] {
      IDLE, GET_HDR, GOT_HDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_STORE, DONE
   } state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic addr_we_q, addr_we_d, sr_we_q, sr_we_d, dm_we_q, dm_we_d;
   logic miso_en_q, miso_en_d, busy_q, busy_d;
   logic abort, last_hdr, last_data;
   always_comb begin
      abort = (state_q != IDLE) && cs_n;
      last_hdr = sclk_rise && (cnt_q == HDR_LAST);
      last_data = sclk_rise && (cnt_q == DATA_LAST);
      state_d = state_q;
      cnt_d = (sclk_rise && (state_q inside {GET_HDR, READ_SHIFT, WRITE_RECV})) ? cnt_q + 1'b1 : cnt_q;
      case (state_q)
         IDLE:        if (!cs_n) begin state_d = GET_HDR; cnt_d = '0; end
         GET_HDR:     if (last_hdr) begin state_d = GOT_HDR; cnt_d = '0; end
         GOT_HDR:     state_d = rw_bit ? READ_WAIT : WRITE_RECV;
         READ_WAIT:   state_d = READ_LOAD;
         READ_LOAD:   state_d = READ_SHIFT;
         READ_SHIFT:  if (last_data) begin state_d = DONE; cnt_d = '0; end
         WRITE_RECV:  if (last_data) begin state_d = WRITE_STORE; cnt_d = '0; end
         WRITE_STORE: state_d = DONE;
         DONE:        state_d = DONE;
         default:     state_d = IDLE;
      endcase
      // Chip-select release beats any terminal edge arriving in the same cycle.
      if (abort) begin state_d = IDLE; cnt_d = '0; end
      addr_we_d = state_d == GOT_HDR;
      sr_we_d = state_d == READ_LOAD;
      dm_we_d = state_d == WRITE_STORE;
      miso_en_d = state_d == READ_SHIFT;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         addr_we_q <= 1'b0;
         sr_we_q <= 1'b0;
         dm_we_q <= 1'b0;
         miso_en_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         addr_we_q <= addr_we_d;
         sr_we_q <= sr_we_d;
         dm_we_q <= dm_we_d;
         miso_en_q <= miso_en_d;
         busy_q <= busy_d;
      end
   end
   assign addr_we = addr_we_q;
   assign sr_we = sr_we_q;
   assign dm_we = dm_we_q;
   assign miso_en = miso_en_q;
   assign busy = busy_q;
`ifdef SPI_FSM_DEBUG_EN
   logic [7:0] abort_cnt_q, abort_cnt_d;
   always_comb
      abort_cnt_d = (abort && state_q != DONE && abort_cnt_q != 8'hff) ? abort_cnt_q + 8'd1 : abort_cnt_q;
   always_ff @(posedge clk) begin
      if (!reset_n) abort_cnt_q <= '0;
      else abort_cnt_q <= abort_cnt_d;
   end
   assign dbg_state = state_q;
   assign abort_cnt = abort_cnt_q;
`endif
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: randomized transaction stimulus with a scoreboard of timed output events.
module tb_spi_fsm;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sclk_rise = 1'b0;
   logic cs_n = 1'b1;
   logic rw_bit = 1'b0;
   logic addr_we, sr_we, dm_we, miso_en, busy;
`ifdef SPI_FSM_DEBUG_EN
   logic [3:0] dbg_state;
   logic [7:0] abort_cnt;
   int exp_abort = 0;
`endif

   spi_fsm dut (
      .clk(clk), .reset_n(reset_n), .sclk_rise(sclk_rise), .cs_n(cs_n), .rw_bit(rw_bit),
      .addr_we(addr_we), .sr_we(sr_we), .dm_we(dm_we), .miso_en(miso_en), .busy(busy)
`ifdef SPI_FSM_DEBUG_EN
      , .dbg_state(dbg_state), .abort_cnt(abort_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int k;
   } ev_t;
   ev_t sb[$];
   ev_t tq[$];
   int n_checks = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;
   logic miso_p = 1'b0;
   logic busy_p = 1'b0;
   logic [6:0] ev_m;
   string kname[7] = '{"addr_we", "sr_we", "dm_we", "miso_rise", "miso_fall", "busy_rise", "busy_fall"};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, exp);
   endtask

   task automatic check_ev(input int k);
      ev_t e;
      n_checks++;
      if (sb.size() == 0) begin
         $display("FAIL event: got unexpected %s at cycle %0d, want nothing", kname[k], cyc);
      end else begin
         e = sb.pop_front();
         if (e.k == k && e.c == cyc) n_pass++;
         else $display("FAIL event: got %s at cycle %0d, want %s at cycle %0d", kname[k], cyc, kname[e.k], e.c);
      end
   endtask

   always @(negedge clk) begin
      ev_m = {busy_p & ~busy, busy & ~busy_p, miso_p & ~miso_en, miso_en & ~miso_p, dm_we, sr_we, addr_we};
      if (mon_en)
         for (int k = 0; k < 7; k++)
            if (ev_m[k]) check_ev(k);
      miso_p = miso_en;
      busy_p = busy;
   end

   task automatic push(input int c, input int k);
      ev_t e;
      e.c = c;
      e.k = k;
      sb.push_back(e);
   endtask

   task automatic add(input int c, input int k);
      ev_t e;
      int i;
      e.c = c;
      e.k = k;
      i = 0;
      while (i < tq.size() && (tq[i].c < c || (tq[i].c == c && tq[i].k < k))) i++;
      tq.insert(i, e);
   endtask

   // One transaction: 16 SCLK rises (8 header, 8 data); cs_n rises after rise ab_idx + ab_dly
   // slots, or after completion when ab_idx < 0. Expected events are those of a full
   // transaction up to the release slot, then the release itself.
   task automatic run_txn(input bit rd, input int ab_idx, input int ab_dly);
      int ro[16];
      bit rise_at[200];
      int base, e_off, e, t_hdr, t_last, mr, mf, done_at, tail;
      base = cyc + 1;
      for (int i = 0; i < 200; i++) rise_at[i] = 1'b0;
      ro[0] = 1 + $urandom_range(0, 3);
      for (int i = 1; i < 16; i++) ro[i] = ro[i-1] + $urandom_range(4, 7);
      for (int i = 0; i < 16; i++) rise_at[ro[i]] = 1'b1;
      if (ab_idx < 0) begin
         e_off = ro[15] + $urandom_range(3, 6);
         rise_at[ro[15] + 2] = 1'b1;
      end else e_off = ro[ab_idx] + ab_dly;
      e = base + e_off;
      t_hdr = base + ro[7];
      t_last = base + ro[15];
      mr = t_hdr + 4;
      mf = t_last + 1;
      done_at = rd ? t_last + 1 : t_last + 2;
      tq.delete();
      add(base + 1, 5);
      add(t_hdr + 1, 0);
      if (rd) begin
         add(t_hdr + 3, 1);
         add(mr, 3);
         add(mf, 4);
      end else add(t_last + 1, 2);
      foreach (tq[i]) if (tq[i].c <= e) sb.push_back(tq[i]);
      if (rd && mr <= e && e < mf) push(e + 1, 4);
      push(e + 1, 6);
`ifdef SPI_FSM_DEBUG_EN
      if (e < done_at && exp_abort < 255) exp_abort++;
`endif
      tail = $urandom_range(1, 3);
      rw_bit = rd;
      for (int off = 0; off <= e_off + tail; off++) begin
         @(posedge clk); #1;
         cs_n = (off >= e_off);
         sclk_rise = (off <= e_off) ? rise_at[off] : 1'($urandom_range(0, 1));
      end
      sclk_rise = 1'b0;
`ifdef SPI_FSM_DEBUG_EN
      @(posedge clk); #1;
      chk("abort_cnt", 32'(abort_cnt), 32'(exp_abort));
`endif
   endtask

   task automatic noise();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         cs_n = 1'b1;
         sclk_rise = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      sclk_rise = 1'b0;
      chk("noise_idle", 32'({addr_we, sr_we, dm_we, miso_en, busy}), 32'd0);
   endtask

   task automatic reset_mid();
      int base;
      base = cyc + 1;
      push(base + 1, 5);
      push(base + 13, 6);
      rw_bit = 1'b0;
      for (int off = 0; off < 16; off++) begin
         @(posedge clk); #1;
         reset_n = !(off == 12 || off == 13);
         cs_n = (off >= 14);
         sclk_rise = (off == 2 || off == 6 || off == 10);
         if (off == 13) chk("mid_reset_outputs", 32'({addr_we, sr_we, dm_we, miso_en, busy}), 32'd0);
      end
`ifdef SPI_FSM_DEBUG_EN
      exp_abort = 0;
      chk("mid_reset_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
   endtask

   initial begin
      repeat (3) begin @(posedge clk); #1; end
      chk("reset_outputs", 32'({addr_we, sr_we, dm_we, miso_en, busy}), 32'd0);
`ifdef SPI_FSM_DEBUG_EN
      chk("reset_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
      reset_n = 1'b1;
      mon_en = 1'b1;
      run_txn(1'b0, -1, 0);
      run_txn(1'b1, -1, 0);
      run_txn(1'b0, 12, 2);
      run_txn(1'b0, 7, 0);
      run_txn(1'b1, 7, 0);
      noise();
      reset_mid();
      run_txn(1'b1, -1, 0);
      for (int n = 0; n < 40; n++)
         run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
      repeat (5) begin @(posedge clk); #1; end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
